// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the 1-to-4 demux scheduler and its round-robin picker.
package demux_sched_pkg;

    localparam int NCH = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [3:0] onehot4(input ch_t ch);
        onehot4 = 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set mask bit scanning ptr, ptr+1, ... modulo 4.
module rr_pick4
    import demux_sched_pkg::*;
(
    input  ch_t        ptr,
    input  logic [3:0] mask,
    output ch_t        pick,
    output logic       pick_ok
);

    ch_t idx;

    // Scan from the farthest offset down so the nearest enabled channel wins last.
    always_comb begin
        pick    = ptr;
        pick_ok = 1'b0;
        idx     = ptr;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = ptr + ch_t'(i);
            if (mask[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1x4_scheduler.sv
// Registered 1-to-4 dispatcher with fixed or round-robin steering and a one-word output register.
// Optional per-channel delivery counters are built only when DEMUX_SCHED_CNT_EN is defined.
module demux_1x4_scheduler
    import demux_sched_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [1:0]         sel,
    input  logic [3:0]         en_mask,
    output logic [DW-1:0]      out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               busy,
    input  logic               clr_cnt,
    output logic [4*CNT_W-1:0] cnt_flat
);

    // Handshake: a transfer happens on any cycle where valid and ready are both high.
    // Ready never depends on valid of the same port; a held word keeps out_valid/out_data
    // stable until its consumer takes it.

    state_e        state_q, state_d;
    ch_t           dst_q, ptr_q;
    ch_t           rr_pick, cand;
    logic          rr_ok, cand_ok;
    logic          hold, out_fire, in_fire;
    logic [DW-1:0] data_q;

    rr_pick4 u_rr_pick4 (
        .ptr     (ptr_q),
        .mask    (en_mask),
        .pick    (rr_pick),
        .pick_ok (rr_ok)
    );

    always_comb begin
        if (mode == MODE_RR) begin
            cand    = rr_pick;
            cand_ok = rr_ok;
        end else begin
            cand    = sel;
            cand_ok = en_mask[sel];
        end
    end

    assign hold     = (state_q == HOLD);
    assign out_fire = hold & out_ready[dst_q];
    // Accepting in the same cycle the held word leaves gives back-to-back throughput.
    assign in_ready = cand_ok & (~hold | out_fire);
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_fire) state_d = HOLD;
            HOLD:    if (out_fire && !in_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            dst_q  <= '0;
            ptr_q  <= '0;
        end else if (in_fire) begin
            data_q <= in_data;
            dst_q  <= cand;
            if (mode == MODE_RR) begin
                ptr_q <= ch_t'(rr_pick + 2'd1);
            end
        end
    end

    assign out_valid = hold ? onehot4(dst_q) : 4'b0000;
    assign out_data  = data_q;
    assign busy      = hold;

`ifdef DEMUX_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];

    // Clear has priority over a coincident delivery; counts saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
        end else if (out_fire && (cnt_q[dst_q] != {CNT_W{1'b1}})) begin
            cnt_q[dst_q] <= cnt_q[dst_q] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_flat
        assign cnt_flat[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign cnt_flat       = '0;
`endif

endmodule

// File: tb/tb_demux_1x4_scheduler.sv
// Self-checking bench for demux_1x4_scheduler: reference model plus expected-word queue.
module tb_demux_1x4_scheduler;
    import demux_sched_pkg::*;

    localparam int DW    = 8;
    localparam int CNT_W = 8;
    localparam int W     = DW + 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst_n;
    logic [DW-1:0]      in_data;
    logic               in_valid;
    logic               in_ready;
    logic               mode;
    logic [1:0]         sel;
    logic [3:0]         en_mask;
    logic [DW-1:0]      out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic               busy;
    logic               clr_cnt;
    logic [4*CNT_W-1:0] cnt_flat;

    demux_1x4_scheduler #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .en_mask   (en_mask),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .clr_cnt   (clr_cnt),
        .cnt_flat  (cnt_flat)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int            checks = 0;
    int            errors = 0;
    logic [W-1:0]  exp_q[$];
    logic [3:0]    fire_log[$];
    ch_t           ptr_m;
    int            cnt_m[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_cand(output ch_t c, output logic ok);
        c  = sel;
        ok = 1'b0;
        if (mode == MODE_RR) begin
            for (int k = 0; k < 4; k++) begin
                ch_t t;
                t = ch_t'((int'(ptr_m) + k) % 4);
                if (!ok && en_mask[t]) begin
                    c  = t;
                    ok = 1'b1;
                end
            end
        end else begin
            ok = en_mask[sel];
        end
    endtask

    task automatic monitor_step();
        logic         held, ofire, ok, exp_rdy;
        logic [W-1:0] head;
        ch_t          hch, c;
        if (!rst_n) begin
            exp_q.delete();
            ptr_m = '0;
            for (int i = 0; i < 4; i++) cnt_m[i] = 0;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_out_data", out_data, 0);
            check("rst_cnt", cnt_flat, 0);
            return;
        end
        held = (exp_q.size() != 0);
        head = held ? exp_q[0] : '0;
        hch  = head[W-1:DW];
        check("out_valid", out_valid, held ? onehot4(hch) : 4'b0000);
        check("busy", busy, held);
        if (held) check("out_data", out_data, head[DW-1:0]);
        ofire = held && out_ready[hch];
        model_cand(c, ok);
        exp_rdy = ok && (!held || ofire);
        check("in_ready", in_ready, exp_rdy);
`ifdef DEMUX_SCHED_CNT_EN
        for (int i = 0; i < 4; i++) check("cnt", cnt_flat[i*CNT_W +: CNT_W], cnt_m[i]);
`else
        check("cnt_off", cnt_flat, 0);
`endif
        if (ofire) begin
            fire_log.push_back(onehot4(hch));
            void'(exp_q.pop_front());
        end
        if (clr_cnt) begin
            for (int i = 0; i < 4; i++) cnt_m[i] = 0;
        end else if (ofire && cnt_m[hch] < CMAX) begin
            cnt_m[hch]++;
        end
        if (in_valid && exp_rdy) begin
            exp_q.push_back({c, in_data});
            if (mode == MODE_RR) ptr_m = ch_t'(c + 2'd1);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #3;
            monitor_step();
        end
    end

    // driver
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] mk,
                        input logic [3:0] rdy, input logic v, input logic [7:0] d,
                        input logic clr);
        @(negedge clk);
        mode      = m;
        sel       = s;
        en_mask   = mk;
        out_ready = rdy;
        in_valid  = v;
        in_data   = d;
        clr_cnt   = clr;
    endtask

    logic [3:0] rr_exp [6];

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; mode = 1'b0; sel = '0;
        en_mask = 4'hF; out_ready = 4'hF; clr_cnt = 1'b0;
        repeat (3) step(0, 0, 4'hF, 4'hF, 0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fixed routing
        step(0, 2, 4'hF, 4'hF, 1, 8'hA5, 0);
        step(0, 2, 4'hF, 4'hF, 0, 8'h00, 0);
        #1;
        check("fx_out_valid", out_valid, 4'b0100);
        check("fx_out_data", out_data, 8'hA5);
        step(0, 2, 4'hF, 4'hF, 0, 8'h00, 0);
`ifdef DEMUX_SCHED_CNT_EN
        #1 check("fx_cnt2", cnt_flat[2*CNT_W +: CNT_W], 1);
`endif

        // round-robin with masked channel 2
        fire_log.delete();
        for (int k = 1; k <= 6; k++) step(1, 0, 4'b1011, 4'hF, 1, 8'(k), 0);
        step(1, 0, 4'b1011, 4'hF, 0, 8'h00, 0);
        step(1, 0, 4'b1011, 4'hF, 0, 8'h00, 0);
        rr_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        check("rr_count", fire_log.size(), 6);
        for (int k = 0; k < 6; k++)
            if (k < fire_log.size()) check("rr_order", fire_log[k], rr_exp[k]);

        // backpressure then same-cycle handoff
        step(0, 1, 4'hF, 4'h0, 1, 8'h11, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 4'hF, 4'h0, 1, 8'h22, 0);
            #1;
            check("bp_out_data", out_data, 8'h11);
            check("bp_out_valid", out_valid, 4'b0010);
            check("bp_in_ready", in_ready, 0);
        end
        step(0, 1, 4'hF, 4'b0010, 1, 8'h22, 0);
        #1 check("bp_handoff_ready", in_ready, 1);
        step(0, 1, 4'hF, 4'hF, 0, 8'h00, 0);
        #1;
        check("bp_next_data", out_data, 8'h22);
        check("bp_next_valid", out_valid, 4'b0010);
        step(0, 1, 4'hF, 4'hF, 0, 8'h00, 0);

        // stall on masked fixed select, then on empty RR mask
        for (int k = 0; k < 6; k++) begin
            step(0, 3, 4'b0111, 4'hF, 1, 8'h33, 0);
            #1 check("stall_fixed", in_ready, 0);
        end
        step(0, 3, 4'hF, 4'hF, 1, 8'h33, 0);
        #1 check("stall_release", in_ready, 1);
        step(0, 3, 4'hF, 4'hF, 0, 8'h00, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 4'h0, 4'hF, 1, 8'h44, 0);
            #1 check("stall_rr", in_ready, 0);
        end
        step(1, 0, 4'hF, 4'hF, 0, 8'h00, 0);

        // counter saturation and clear priority
        step(0, 0, 4'hF, 4'hF, 0, 8'h00, 1);
        for (int k = 0; k < 256; k++) step(0, 0, 4'hF, 4'hF, 1, 8'(k), 0);
        step(0, 0, 4'hF, 4'hF, 0, 8'h00, 0);
        step(0, 0, 4'hF, 4'hF, 0, 8'h00, 0);
`ifdef DEMUX_SCHED_CNT_EN
        #1 check("cnt0_sat", cnt_flat[0 +: CNT_W], CMAX);
`endif
        step(0, 0, 4'hF, 4'hF, 1, 8'h55, 0);
        step(0, 0, 4'hF, 4'hF, 0, 8'h00, 1);
        step(0, 0, 4'hF, 4'hF, 0, 8'h00, 0);
        #1 check("cnt_clr_fire", cnt_flat, 0);

        // randomized traffic
        repeat (300) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 31) == 0);
        end
        repeat (4) step(0, 0, 4'hF, 4'hF, 0, 8'h00, 0);

        // async reset mid-hold
        step(0, 1, 4'hF, 4'h0, 1, 8'h66, 0);
        step(0, 1, 4'hF, 4'h0, 0, 8'h00, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        fire_log.delete();
        step(1, 0, 4'b1100, 4'hF, 1, 8'h77, 0);
        step(1, 0, 4'b1100, 4'hF, 0, 8'h00, 0);
        step(1, 0, 4'b1100, 4'hF, 0, 8'h00, 0);
        check("arst_fire_count", fire_log.size(), 1);
        if (fire_log.size() > 0) check("arst_first_rr", fire_log[0], 4'b0100);
        repeat (2) step(0, 0, 4'hF, 4'hF, 0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1x4_scheduler.md
Name: demux_1x4_scheduler

Overview:
- Registered dispatcher that feeds a 1-to-4 demultiplexed datapath. One valid/ready input stream is steered to one of four output channels.
- The destination is either a fixed select or round-robin across enabled channels. Round-robin skips masked channels.
- Holds one word in an output register and tracks per-channel delivery counts.
- Sits between a single producer and four consumer lanes.

Parameters:
- DW, 8, data word width.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  input word.
- in_valid  in  1  input word valid.
- in_ready  out  1  scheduler can accept a word this cycle.
- mode  in  1  0 = fixed (use sel), 1 = round-robin.
- sel  in  2  destination channel in fixed mode.
- en_mask  in  4  per-channel enable; bit i = 1 means channel i may receive.
- out_data  out  DW  held word, shared by all channels.
- out_valid  out  4  one-hot valid for the destination channel.
- out_ready  in  4  per-channel consumer ready.
- busy  out  1  a word is held (state HOLD).
- clr_cnt  in  1  synchronous clear of all counters.
- cnt_flat  out  4*CNT_W  counters; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=4'b0000, out_data=0, busy=0, rr pointer=0, all counters=0. Asserting reset mid-HOLD drops the held word immediately with no partial delivery.
- State IDLE (no word held): out_valid=0, busy=0.
- State HOLD (word held): out_valid = onehot(dst), busy=1.
- Output fire: out_fire = HOLD & out_ready[dst].
- Candidate channel:
  - Fixed mode: cand=sel; cand_ok=en_mask[sel].
  - RR mode: cand = first i with en_mask[i]=1, scanning ptr, ptr+1, … modulo 4; cand_ok = |en_mask.
- in_ready = cand_ok & (IDLE | out_fire). This gives full throughput with no bubble on back-to-back transfers.
- Accept: in_fire = in_valid & in_ready. On in_fire, out_data<=in_data, dst<=cand, state<=HOLD. Latency is 1 cycle from accept to out_valid.
- RR pointer: on in_fire in RR mode, ptr <= cand+1 (mod 4). Fixed-mode accepts do not move ptr.
- Transitions:
  - IDLE -> HOLD on in_fire.
  - HOLD -> HOLD on out_fire & in_fire (new word and new dst loaded).
  - HOLD -> IDLE on out_fire & !in_fire.
  - Otherwise stay in the current state.
- Held word is stable: out_data and dst do not change while waiting. Changes to mode, sel or en_mask affect only the next accept. Clearing the held channel's en_mask bit does not retract out_valid.
- No channel available (fixed-mode sel masked, or en_mask=0 in RR mode): in_ready=0 and the input stalls. No word is ever dropped.
- Counters: cnt[dst] increments on out_fire and saturates at 2^CNT_W-1.
  - clr_cnt=1 sets all counters to 0.
  - clr_cnt and out_fire in the same cycle: clear wins, result 0.
- Invariant: out_valid is always zero or one-hot.

Optional Feature:
- Macro: DEMUX_SCHED_CNT_EN.
- Defined: counters, clr_cnt behaviour and saturation exactly as above.
- Undefined: no counter flops. cnt_flat is tied to 0 and clr_cnt is ignored. Ports are unchanged.

Decomposition:
- Package demux_sched_pkg holds:
  - NCH=4.
  - typedef logic [1:0] ch_t.
  - enum mode_e {MODE_FIXED=0, MODE_RR=1}.
  - enum state_e {IDLE, HOLD}.
  - function onehot4(ch_t) returning logic [3:0].
- Sub-module rr_pick4: combinational. Inputs: ptr (ch_t) and mask (4 bits). Outputs: pick (ch_t) and pick_ok. Reused by other team arbiters.

Test Plan:
- Fixed routing: mode=0, en_mask=4'hF, out_ready=4'hF; send 0xA5 with sel=2 -> next cycle out_valid=4'b0100, out_data=0xA5; after fire cnt2=1.
- Round-robin with mask: mode=1, en_mask=4'b1011, stream 0x01..0x06 with out_ready all 1 -> channels 0,1,3,0,1,3; one word/cycle, in_ready never low.
- Backpressure: hold word on ch1 with out_ready=0 for 5 cycles -> out_data/out_valid stable, in_ready=0. Raise out_ready[1] with a pending input -> same-cycle handoff, next word loaded with no bubble.
- Stall conditions: mode=0, sel=3, en_mask=4'b0111 -> in_ready=0 indefinitely. Set en_mask[3]=1 -> word accepted. Repeat in RR mode with en_mask=0 -> stall.
- Counter edge: force 255 deliveries to ch0 (CNT_W=8), then 1 more -> cnt0 stays 255. clr_cnt coincident with a fire -> cnt0=0.
- Async reset mid-HOLD: drop rst_n between clock edges -> out_valid=0, busy=0 immediately. After release, ptr=0, so the first RR accept goes to the lowest enabled channel.
